// File: rtl/recfn_pkg.sv
// Shared definitions for the recoded-float <-> IEEE conversion blocks.
package recfn_pkg;

  localparam int FP_BITS_DEF     = 32;
  localparam int EXP_BITS_DEF    = 8;
  localparam int FRA_BITS_DEF    = 23;
  localparam int SIG_BITS_DEF    = 32;
  localparam int RECEXP_BITS_DEF = 9;
  localparam int SHIFT_STEP_DEF  = 8;
  localparam logic [RECEXP_BITS_DEF-1:0] EXP_OFFSET_DEF = 9'h101;

  // Operand class codes, shared with the fp-to-recFN front-end.
  localparam logic [1:0] CLS_FINITE = 2'b00;
  localparam logic [1:0] CLS_ZERO   = 2'b01;
  localparam logic [1:0] CLS_INF    = 2'b10;
  localparam logic [1:0] CLS_NAN    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/recfn_classify.sv
// Splits a finite recoded exponent into normal / subnormal and derives the
// denormalisation shift and the flush-to-zero condition.
module recfn_classify
  import recfn_pkg::*;
#(
  parameter int RECEXP_BITS = RECEXP_BITS_DEF,
  parameter int FRA_BITS    = FRA_BITS_DEF,
  parameter logic [RECEXP_BITS-1:0] EXP_OFFSET = EXP_OFFSET_DEF
) (
  input  logic [1:0]             cls_i,
  input  logic [RECEXP_BITS-1:0] exp_i,
  output logic                   is_normal_o,
  output logic                   is_sub_o,
  output logic [RECEXP_BITS-1:0] shift_o,
  output logic                   flush_o
);

  // Smallest recoded exponent that still maps to a normal IEEE number.
  localparam logic [RECEXP_BITS-1:0] MIN_NORMAL = EXP_OFFSET + RECEXP_BITS'(1);
  localparam logic [RECEXP_BITS-1:0] MAX_SHIFT  = RECEXP_BITS'(FRA_BITS);

  logic is_finite;

  assign is_finite   = (cls_i == CLS_FINITE);
  assign is_normal_o = is_finite && (exp_i >= MIN_NORMAL);
  assign is_sub_o    = is_finite && (exp_i < MIN_NORMAL);
  // Only meaningful when is_sub_o; always >= 1 in that case.
  assign shift_o     = MIN_NORMAL - exp_i;
  // Shifting the hidden one past the last fraction bit leaves nothing.
  assign flush_o     = is_sub_o && (shift_o > MAX_SHIFT);

endmodule

// File: rtl/recfn_to_fn.sv
// Recoded float to packed IEEE-754 converter with an iterative
// denormalising right-shifter.
//
// state    | meaning
// ST_IDLE  | waiting for an operand, in_ready high
// ST_SHIFT | shifting a subnormal significand right, SHIFT_STEP bits/cycle max
// ST_DONE  | result presented on out_fp/out_flush until out_ready
module recfn_to_fn
  import recfn_pkg::*;
#(
  parameter int FP_BITS     = FP_BITS_DEF,
  parameter int EXP_BITS    = EXP_BITS_DEF,
  parameter int FRA_BITS    = FRA_BITS_DEF,
  parameter int SIG_BITS    = SIG_BITS_DEF,
  parameter int RECEXP_BITS = RECEXP_BITS_DEF,
  parameter logic [RECEXP_BITS-1:0] EXP_OFFSET = EXP_OFFSET_DEF,
  parameter int SHIFT_STEP  = SHIFT_STEP_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [RECEXP_BITS-1:0] in_exp,
  input  logic [SIG_BITS-1:0]    in_sig,
  input  logic [1:0]             in_class,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FP_BITS-1:0]     out_fp,
  output logic                   out_flush
);

  localparam logic [RECEXP_BITS-1:0] STEP = RECEXP_BITS'(SHIFT_STEP);

  state_e                 state_q, state_d;
  logic [FRA_BITS:0]      m_q, m_d;
  logic [RECEXP_BITS-1:0] r_q, r_d;
  logic                   sign_q, sign_d;
  logic [FP_BITS-1:0]     fp_q, fp_d;
  logic                   flush_q, flush_d;

  logic                   is_normal, is_sub, is_flush;
  logic [RECEXP_BITS-1:0] shift_amt;
  logic [FRA_BITS-1:0]    frac_in, nan_frac;
  logic [RECEXP_BITS-1:0] exp_diff;
  logic [RECEXP_BITS-1:0] k;
  logic [FRA_BITS:0]      m_shift;
  logic [RECEXP_BITS-1:0] r_rem;
  logic                   unused_bits;

  recfn_classify #(
    .RECEXP_BITS (RECEXP_BITS),
    .FRA_BITS    (FRA_BITS),
    .EXP_OFFSET  (EXP_OFFSET)
  ) u_classify (
    .cls_i       (in_class),
    .exp_i       (in_exp),
    .is_normal_o (is_normal),
    .is_sub_o    (is_sub),
    .shift_o     (shift_amt),
    .flush_o     (is_flush)
  );

  // The explicit leading one, the zero pad and the exponent overflow bit
  // carry no information for the packed result.
  assign frac_in     = in_sig[SIG_BITS-2 -: FRA_BITS];
  assign nan_frac    = (frac_in == '0) ? {1'b1, {(FRA_BITS-1){1'b0}}} : frac_in;
  assign exp_diff    = in_exp - EXP_OFFSET;
  assign unused_bits = ^{in_sig[SIG_BITS-1], in_sig[SIG_BITS-2-FRA_BITS:0],
                         exp_diff[RECEXP_BITS-1:EXP_BITS]};

  assign k       = (r_q < STEP) ? r_q : STEP;
  assign m_shift = m_q >> k;
  assign r_rem   = r_q - k;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_fp    = fp_q;
  assign out_flush = flush_q;

  // State, shifter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      r_q     <= '0;
      sign_q  <= 1'b0;
      fp_q    <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      r_q     <= r_d;
      sign_q  <= sign_d;
      fp_q    <= fp_d;
      flush_q <= flush_d;
    end
  end

  // Decode on accept, step the shifter, and release the result on out_ready.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    r_d     = r_q;
    sign_d  = sign_q;
    fp_d    = fp_q;
    flush_d = flush_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          flush_d = 1'b0;
          sign_d  = in_sign;
          state_d = ST_DONE;
          if (in_class == CLS_ZERO) begin
            fp_d = {in_sign, {(FP_BITS-1){1'b0}}};
          end else if (in_class == CLS_INF) begin
            fp_d = {in_sign, {EXP_BITS{1'b1}}, {FRA_BITS{1'b0}}};
          end else if (in_class == CLS_NAN) begin
            fp_d = {in_sign, {EXP_BITS{1'b1}}, nan_frac};
          end else if (is_normal) begin
            fp_d = {in_sign, exp_diff[EXP_BITS-1:0], frac_in};
          end else if (is_flush) begin
            fp_d    = {in_sign, {(FP_BITS-1){1'b0}}};
            flush_d = 1'b1;
          end else if (is_sub) begin
            m_d     = {1'b1, frac_in};
            r_d     = shift_amt;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        m_d = m_shift;
        r_d = r_rem;
        if (r_rem == '0) begin
          fp_d    = {sign_q, {EXP_BITS{1'b0}}, m_shift[FRA_BITS-1:0]};
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
